// File: rtl/gaussian_conv_pipe.sv
// 7x7 Gaussian convolution: 3-stage pipeline with programmable taps and a kernel-size mask.
// Define GAUSS_ROUND_EN to round half up before normalising; otherwise the shift truncates.
module gaussian_conv_pipe #(
    parameter int BITS      = 8,
    parameter int COEF_BITS = 8,
    parameter int SHIFT     = 10
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [49*BITS-1:0]   in_pixels,
    input  logic [1:0]           ksize,
    input  logic                 coef_we,
    input  logic [5:0]           coef_addr,
    input  logic [COEF_BITS-1:0] coef_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [BITS-1:0]      result
);

    localparam int TAPS   = 49;
    localparam int PROD_W = BITS + COEF_BITS;
    localparam int ACC_W  = BITS + COEF_BITS + 6;

`ifdef GAUSS_ROUND_EN
    localparam logic [ACC_W-1:0] RND = ACC_W'(2 ** (SHIFT - 1));
`else
    localparam logic [ACC_W-1:0] RND = '0;
`endif

    // Rows 0-3 of the reset kernel; rows 4-6 mirror rows 2-0.
    localparam int DEF_TAB [28] = '{
        5,  9, 14, 16, 14,  9,  5,
        9, 18, 26, 29, 26, 18,  9,
        14, 26, 37, 42, 37, 26, 14,
        16, 29, 42, 48, 42, 29, 16
    };

    function automatic logic [COEF_BITS-1:0] default_coef(input int idx);
        int row;
        row = idx / 7;
        if (row > 3) row = 6 - row;
        return COEF_BITS'(DEF_TAB[row*7 + idx%7]);
    endfunction

    logic [COEF_BITS-1:0] coef   [TAPS];
    logic [PROD_W-1:0]    prod_d [TAPS];
    logic [PROD_W-1:0]    prod_q [TAPS];
    logic [ACC_W-1:0]     row_d  [7];
    logic [ACC_W-1:0]     row_q  [7];
    logic [ACC_W-1:0]     total;
    logic [ACC_W-1:0]     scaled;
    logic [BITS-1:0]      sat;
    logic                 v1;
    logic                 v2;
    logic                 advance;

    assign advance  = !out_valid || out_ready;
    assign in_ready = advance;

    // Taps outside the centred ksize window contribute nothing; size 3 behaves as 7x7.
    always_comb begin
        int half;
        half = (ksize == 2'd0) ? 1 : (ksize == 2'd1) ? 2 : 3;
        for (int r = 0; r < 7; r++) begin
            for (int c = 0; c < 7; c++) begin
                prod_d[r*7+c] = '0;
                if (r >= 3 - half && r <= 3 + half && c >= 3 - half && c <= 3 + half)
                    prod_d[r*7+c] = PROD_W'(in_pixels[(TAPS-1-(r*7+c))*BITS +: BITS])
                                  * PROD_W'(coef[r*7+c]);
            end
        end
    end

    always_comb begin
        for (int r = 0; r < 7; r++) begin
            row_d[r] = '0;
            for (int c = 0; c < 7; c++)
                row_d[r] = row_d[r] + ACC_W'(prod_q[r*7+c]);
        end
    end

    always_comb begin
        total = '0;
        for (int r = 0; r < 7; r++)
            total = total + row_q[r];
        scaled = (total + RND) >> SHIFT;
        if (scaled > ACC_W'((2 ** BITS) - 1))
            sat = '1;
        else
            sat = scaled[BITS-1:0];
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            v1        <= 1'b0;
            v2        <= 1'b0;
            out_valid <= 1'b0;
            result    <= '0;
        end else if (advance) begin
            v1        <= in_valid;
            v2        <= v1;
            out_valid <= v2;
            if (v2)
                result <= sat;
        end
    end

    // Stage data carries no reset; the valid bits alone qualify it.
    always_ff @(posedge clk) begin
        if (advance) begin
            prod_q <= prod_d;
            row_q  <= row_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < TAPS; i++)
                coef[i] <= default_coef(i);
        end else if (coef_we && coef_addr <= 6'd48) begin
            coef[coef_addr] <= coef_data;
        end
    end

endmodule

// File: tb/tb_gaussian_conv_pipe.sv
// Self-checking bench for gaussian_conv_pipe: vector table plus coefficient, stall and reset sequences.
// Expected values follow GAUSS_ROUND_EN when it is defined for the build.
module tb_gaussian_conv_pipe;

    localparam int WIN_W = 49 * 8;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic [WIN_W-1:0] in_pixels;
    logic [1:0]       ksize;
    logic             coef_we;
    logic [5:0]       coef_addr;
    logic [7:0]       coef_data;
    logic             out_valid;
    logic             out_ready;
    logic [7:0]       result;

    int total_checks = 0;
    int bad_checks   = 0;

    typedef struct {
        logic [7:0] fill;
        int         tap;
        logic [1:0] ks;
        logic [7:0] expv;
    } vec_t;

    vec_t vecs [15];

    gaussian_conv_pipe dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_pixels (in_pixels),
        .ksize     (ksize),
        .coef_we   (coef_we),
        .coef_addr (coef_addr),
        .coef_data (coef_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    // tap < 0 fills every pixel; otherwise only that tap carries the value.
    function automatic logic [WIN_W-1:0] make_window(input logic [7:0] fill, input int tap);
        logic [WIN_W-1:0] w;
        w = '0;
        for (int i = 0; i < 49; i++)
            if (tap < 0 || tap == i)
                w[(48-i)*8 +: 8] = fill;
        return w;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        total_checks++;
        if (actual !== expected) begin
            bad_checks++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    // Called at posedge+1 with an empty pipeline and out_ready high.
    task automatic applyStimulus(input logic [WIN_W-1:0] win, input logic [1:0] ks,
                                 input logic [7:0] expv, input string name);
        int waited;
        in_pixels = win;
        ksize     = ks;
        in_valid  = 1'b1;
        waited    = 0;
        @(negedge clk);
        while (!in_ready && waited < 10) begin
            @(negedge clk);
            waited++;
        end
        checkOutput({name, " accept"}, 32'(in_ready), 32'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        checkOutput({name, " early valid"}, 32'(out_valid), 32'd0);
        @(posedge clk); #1;
        checkOutput({name, " valid"}, 32'(out_valid), 32'd1);
        checkOutput({name, " result"}, 32'(result), 32'(expv));
    endtask

    initial begin
        int         sent;
        int         got;
        logic       saw_stall;
        logic       prev_hold;
        logic [7:0] prev_res;
        logic       dup;

        vecs[0]  = '{8'd100, -1, 2'd2, 8'd100};
`ifdef GAUSS_ROUND_EN
        vecs[1]  = '{8'd255, -1, 2'd0, 8'd91};
`else
        vecs[1]  = '{8'd255, -1, 2'd0, 8'd90};
`endif
        vecs[2]  = '{8'd255, -1, 2'd2, 8'd255};
        vecs[3]  = '{8'd100, -1, 2'd1, 8'd74};
        vecs[4]  = '{8'd255, -1, 2'd1, 8'd189};
        vecs[5]  = '{8'd255, -1, 2'd3, 8'd255};
        vecs[6]  = '{8'd200, 24, 2'd2, 8'd9};
        vecs[7]  = '{8'd200, 24, 2'd0, 8'd9};
        vecs[8]  = '{8'd0,   -1, 2'd2, 8'd0};
        vecs[9]  = '{8'd255,  0, 2'd2, 8'd1};
        vecs[10] = '{8'd255,  0, 2'd0, 8'd0};
        vecs[11] = '{8'd255, 48, 2'd2, 8'd1};
        vecs[12] = '{8'd255,  1, 2'd2, 8'd2};
        vecs[13] = '{8'd255,  8, 2'd1, 8'd4};
        vecs[14] = '{8'd255,  8, 2'd0, 8'd0};

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_pixels = '0;
        ksize     = 2'd2;
        coef_we   = 1'b0;
        coef_addr = '0;
        coef_data = '0;
        out_ready = 1'b0;

        repeat (3) @(posedge clk);
        #1;
        checkOutput("reset out_valid", 32'(out_valid), 32'd0);
        checkOutput("reset result", 32'(result), 32'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;
        checkOutput("in_ready after reset", 32'(in_ready), 32'd1);
        out_ready = 1'b1;

        for (int i = 0; i < 15; i++)
            applyStimulus(make_window(vecs[i].fill, vecs[i].tap), vecs[i].ks, vecs[i].expv,
                          $sformatf("vec%0d", i));
        @(posedge clk); #1;

        // Five-window stream with a four-cycle downstream stall.
        sent      = 0;
        got       = 0;
        saw_stall = 1'b0;
        prev_hold = 1'b0;
        prev_res  = '0;
        for (int cyc = 0; cyc < 60 && got < 5; cyc++) begin
            in_valid  = (sent < 5);
            in_pixels = make_window(8'((sent + 1) * 10), -1);
            ksize     = 2'd2;
            out_ready = !(cyc >= 2 && cyc <= 5);
            @(negedge clk);
            if (prev_hold) begin
                checkOutput("stall hold valid", 32'(out_valid), 32'd1);
                checkOutput("stall hold result", 32'(result), 32'(prev_res));
            end
            prev_hold = out_valid && !out_ready;
            prev_res  = result;
            if (!in_ready) saw_stall = 1'b1;
            if (in_valid && in_ready) sent++;
            if (out_valid && out_ready) begin
                checkOutput($sformatf("stream%0d", got), 32'(result), 32'((got + 1) * 10));
                got++;
            end
            @(posedge clk); #1;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        checkOutput("stream count", 32'(got), 32'd5);
        checkOutput("in_ready dropped", 32'(saw_stall), 32'd1);
        dup = 1'b0;
        repeat (4) begin
            @(negedge clk);
            if (out_valid) dup = 1'b1;
        end
        checkOutput("stream no duplicate", 32'(dup), 32'd0);
        @(posedge clk); #1;

        // Same-cycle coefficient write must not affect the window accepted with it.
        in_pixels = make_window(8'd200, 24);
        ksize     = 2'd2;
        in_valid  = 1'b1;
        coef_we   = 1'b1;
        coef_addr = 6'd24;
        coef_data = 8'd0;
        @(posedge clk); #1;
        coef_we   = 1'b0;
        @(posedge clk); #1;
        in_pixels = make_window(8'd200, 23);
        @(posedge clk); #1;
        in_valid  = 1'b0;
        checkOutput("coef old valid", 32'(out_valid), 32'd1);
        checkOutput("coef old result", 32'(result), 32'd9);
        @(posedge clk); #1;
        checkOutput("coef new valid", 32'(out_valid), 32'd1);
        checkOutput("coef new result", 32'(result), 32'd0);
        @(posedge clk); #1;
        checkOutput("coef neighbour result", 32'(result), 32'd8);
        @(posedge clk); #1;

        // Reset with two windows in flight.
        in_pixels = make_window(8'd100, -1);
        in_valid  = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        in_valid  = 1'b0;
        rst_n     = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        checkOutput("flight reset valid", 32'(out_valid), 32'd0);
        checkOutput("flight reset result", 32'(result), 32'd0);
        dup = 1'b0;
        repeat (5) begin
            @(negedge clk);
            if (out_valid) dup = 1'b1;
        end
        checkOutput("flight reset no stale", 32'(dup), 32'd0);
        @(posedge clk); #1;
        applyStimulus(make_window(8'd200, 24), 2'd2, 8'd9, "default coef restored");

        $display("test done: total=%0d bad=%0d", total_checks, bad_checks);
        $finish;
    end

endmodule

// File: doc/gaussian_conv_pipe.md
GAUSSIAN_CONV_PIPE -- requirements
Module: gaussian_conv_pipe

Interface
REQ-001 The block SHALL take parameter BITS, default 8, as the pixel and result width.
REQ-002 The block SHALL take parameter COEF_BITS, default 8, as the unsigned coefficient width.
REQ-003 The block SHALL take parameter SHIFT, default 10, as the normalisation right-shift.
REQ-004 The window SHALL be fixed at 7x7 (49 taps); ACC_W = BITS+COEF_BITS+6 is the derived accumulator width.
REQ-005 The block SHALL have one clock and a synchronous, active-low reset; the ports are listed below, clock and reset first.
REQ-006 clk  in  1  rising-edge clock for all state.
REQ-007 rst_n  in  1  synchronous active-low reset.
REQ-008 in_valid  in  1  window present on in_pixels.
REQ-009 in_ready  out  1  block accepts window this cycle.
REQ-010 in_pixels  in  49*BITS  row-major window; MSB slice = row0/col0, LSB slice = row6/col6.
REQ-011 ksize  in  2  kernel size: 0=3x3, 1=5x5, 2=7x7, 3 treated as 7x7; sampled on acceptance.
REQ-012 coef_we  in  1  coefficient write strobe.
REQ-013 coef_addr  in  6  tap index 0..48, row-major.
REQ-014 coef_data  in  COEF_BITS  coefficient value.
REQ-015 out_valid  out  1  result valid.
REQ-016 out_ready  in  1  downstream accepts result.
REQ-017 result  out  BITS  filtered pixel.

Function
REQ-018 A window SHALL be accepted on any cycle in which in_valid and in_ready are both high.
REQ-019 Pipeline: S1 = 49 products, with taps outside the centred ksize window forced to 0; S2 = 7 row sums; S3 = total, normalise, saturate into the result register.
REQ-020 Latency SHALL be 3 cycles from acceptance to out_valid when unstalled; throughput SHALL be 1 window per cycle.
REQ-021 The pipeline SHALL advance when (!out_valid || out_ready); in_ready SHALL equal that same condition; a stall SHALL hold every stage's data and valid bits unchanged.
REQ-022 result and out_valid SHALL remain stable while out_valid && !out_ready.
REQ-023 Normalised value = (sum [+ 2^(SHIFT-1) per REQ-030]) >> SHIFT, computed in ACC_W bits without overflow; values above 2^BITS-1 SHALL saturate to 2^BITS-1.
REQ-024 A coefficient write (coef_we high, coef_addr <= 48) SHALL update the register at the clock edge; writes with coef_addr > 48 SHALL be ignored.
REQ-025 A window accepted in the same cycle as a coefficient write SHALL use the old value; windows accepted later SHALL use the new value; windows already in flight SHALL be unaffected.
REQ-026 ksize changes SHALL affect only windows accepted after the change; in-flight windows keep the size they were accepted with.

Reset
REQ-027 When rst_n is low at a clock edge, out_valid and all stage valid bits SHALL clear to 0 and result SHALL clear to 0, discarding in-flight data.
REQ-028 Reset SHALL load the default coefficient rows: [5 9 14 16 14 9 5], [9 18 26 29 26 18 9], [14 26 37 42 37 26 14], [16 29 42 48 42 29 16], then rows 4-6 mirror rows 2-0; the coefficients sum to 1028.
REQ-029 in_ready SHALL be 1 in the cycle after reset deasserts.

Configuration
REQ-030 With macro GAUSS_ROUND_EN defined, 2^(SHIFT-1) SHALL be added before the shift (round half up); without it the shift SHALL truncate.

Verification
REQ-031 All pixels 100, ksize=2, default coefficients, out_ready=1 -> result 100 three cycles after acceptance (both builds).
REQ-032 All pixels 255, ksize=0 -> result 90 (truncate) / 91 (GAUSS_ROUND_EN).
REQ-033 All pixels 255, ksize=2 -> truncate 255; round sum 256 saturates to 255.
REQ-034 Write coef 24 = 0, then centre-only pixel 200 with the rest 0 -> result 0; before the write the result is 9.
REQ-035 Stream 5 windows while out_ready=0 for 4 cycles -> in_ready drops, no result lost or duplicated, and output order is preserved.
REQ-036 Assert rst_n=0 with 2 windows in flight -> out_valid 0 next cycle, no stale result later, coefficients back to defaults.
